fast_window_ctrl: RTL and testbench



---
 rtl/fast_pkg.sv | 16 +
 rtl/fast_xy_counter.sv | 28 ++
 rtl/fast_window_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fast_window_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared constants for the FAST window frame sequencer
package fast_pkg;

    localparam int BORDER = 3;

    localparam logic [1:0] RES_NONE     = 2'b00;
    localparam logic [1:0] RES_640X480  = 2'b01;
    localparam logic [1:0] RES_1280X720 = 2'b10;
    localparam logic [1:0] RES_ANY      = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/fast_xy_counter.sv
// rtl/fast_xy_counter.sv - raster x/y counter, x wraps at last_x and carries into y
module fast_xy_counter #(
    parameter int DIM_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIM_W-1:0] last_x,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == last_x) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_window_ctrl.sv
// rtl/fast_window_ctrl.sv - FAST 7x7 window frame sequencer; FAST_WIN_STATS_EN adds win_valid counters
module fast_window_ctrl #(
    parameter int DIM_W         = 11,
    parameter int BORDER        = fast_pkg::BORDER,
    parameter int ALLOW_ANY_RES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_H_SYNC,
    input  logic             in_V_SYNC,
    input  logic             in_data_en,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic             shift_en,
    output logic             pad_sel,
    output logic [1:0]       res_code,
    output logic [DIM_W-1:0] center_x,
    output logic [DIM_W-1:0] center_y,
    output logic             center_vld,
    output logic             win_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             cfg_error
`ifdef FAST_WIN_STATS_EN
    ,
    output logic [21:0]      valid_cnt,
    output logic [21:0]      valid_cnt_last
`endif
);

    localparam int OFF_W = DIM_W + 2;
    localparam int CNT_W = 2 * DIM_W + 1;

    logic [1:0]       state;
    logic             vsync_d;
    logic [DIM_W-1:0] w_reg, h_reg, last_x;
    logic [OFF_W-1:0] flush_len, flush_cnt;
    logic [CNT_W-1:0] cnt_shift;
    logic [DIM_W-1:0] in_x, in_y, ctr_x, ctr_y;
    logic [1:0]       res_next;
    logic             vsync_rise, accept, in_shift, last_pix, center_now, in_win;
    logic             unused_hsync;

    assign unused_hsync = in_H_SYNC;
    assign vsync_rise   = in_V_SYNC & ~vsync_d;
    assign last_x       = w_reg - 1'b1;
    // Center lags the newest pixel by 3 lines plus 3 pixels.
    assign flush_len    = ({2'b00, w_reg} << 1) + {2'b00, w_reg} + OFF_W'(3);

    always_comb begin
        res_next = fast_pkg::RES_NONE;
        if (width == DIM_W'(640) && height == DIM_W'(480))
            res_next = fast_pkg::RES_640X480;
        else if (width == DIM_W'(1280) && height == DIM_W'(720))
            res_next = fast_pkg::RES_1280X720;
        else if (ALLOW_ANY_RES != 0 && width >= DIM_W'(2 * BORDER + 2) &&
                 height >= DIM_W'(2 * BORDER + 2))
            res_next = fast_pkg::RES_ANY;
    end

    assign accept     = (state == fast_pkg::IDLE) && vsync_rise && (res_next != fast_pkg::RES_NONE);
    assign in_shift   = (state == fast_pkg::RUN) && in_data_en;
    assign shift_en   = in_shift || (state == fast_pkg::FLUSH);
    assign pad_sel    = (state == fast_pkg::FLUSH);
    assign last_pix   = in_shift && (in_x == last_x) && (in_y == h_reg - 1'b1);
    assign center_now = shift_en && (cnt_shift >= CNT_W'(flush_len));
    assign in_win     = (ctr_x >= DIM_W'(BORDER)) && (ctr_x <= w_reg - DIM_W'(BORDER + 1)) &&
                        (ctr_y >= DIM_W'(BORDER)) && (ctr_y <= h_reg - DIM_W'(BORDER + 1));

    fast_xy_counter #(.DIM_W(DIM_W)) u_in_xy (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (in_shift),
        .last_x (last_x),
        .x      (in_x),
        .y      (in_y)
    );

    fast_xy_counter #(.DIM_W(DIM_W)) u_ctr_xy (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (center_now),
        .last_x (last_x),
        .x      (ctr_x),
        .y      (ctr_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= fast_pkg::IDLE;
            vsync_d     <= 1'b0;
            w_reg       <= '0;
            h_reg       <= '0;
            res_code    <= fast_pkg::RES_NONE;
            flush_cnt   <= '0;
            cnt_shift   <= '0;
            center_x    <= '0;
            center_y    <= '0;
            center_vld  <= 1'b0;
            win_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            vsync_d     <= in_V_SYNC;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            center_vld  <= center_now;
            win_valid   <= center_now && in_win;
            if (center_now) begin
                center_x <= ctr_x;
                center_y <= ctr_y;
            end
            if (shift_en)
                cnt_shift <= cnt_shift + 1'b1;
            case (state)
                fast_pkg::IDLE: begin
                    if (vsync_rise) begin
                        res_code <= res_next;
                        w_reg    <= width;
                        h_reg    <= height;
                        if (accept) begin
                            state       <= fast_pkg::RUN;
                            frame_start <= 1'b1;
                            cnt_shift   <= '0;
                            center_x    <= '0;
                            center_y    <= '0;
                            cfg_error   <= 1'b0;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                fast_pkg::RUN: begin
                    if (vsync_rise)
                        cfg_error <= 1'b1;
                    if (last_pix) begin
                        state     <= fast_pkg::FLUSH;
                        flush_cnt <= '0;
                    end
                end
                fast_pkg::FLUSH: begin
                    if (vsync_rise)
                        cfg_error <= 1'b1;
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == flush_len - 1'b1)
                        state <= fast_pkg::DONE;
                end
                default: begin
                    state      <= fast_pkg::IDLE;
                    frame_done <= 1'b1;
                end
            endcase
        end
    end

`ifdef FAST_WIN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_cnt      <= '0;
            valid_cnt_last <= '0;
        end else begin
            if (frame_start)
                valid_cnt <= '0;
            else if (win_valid)
                valid_cnt <= valid_cnt + 1'b1;
            if (frame_done)
                valid_cnt_last <= valid_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_fast_window_ctrl.sv
// tb/tb_fast_window_ctrl.sv - scoreboard bench for fast_window_ctrl (strict and any-resolution instances)
module tb_fast_window_ctrl;

    typedef struct {
        int x;
        int y;
        bit wv;
    } center_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [10:0] width = '0;
    logic [10:0] height = '0;

    logic        a_shift_en, a_pad_sel, a_center_vld, a_win_valid, a_frame_start, a_frame_done, a_cfg_error;
    logic [1:0]  a_res_code;
    logic [10:0] a_center_x, a_center_y;
    logic        b_shift_en, b_pad_sel, b_center_vld, b_win_valid, b_frame_start, b_frame_done, b_cfg_error;
    logic [1:0]  b_res_code;
    logic [10:0] b_center_x, b_center_y;
`ifdef FAST_WIN_STATS_EN
    logic [21:0] a_valid_cnt, a_valid_cnt_last, b_valid_cnt, b_valid_cnt_last;
`endif

    int      compared = 0;
    int      mismatched = 0;
    center_t exp_q[$];

    always #5 clk = ~clk;

    fast_window_ctrl #(.DIM_W(11), .BORDER(3), .ALLOW_ANY_RES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_H_SYNC(hs), .in_V_SYNC(vs), .in_data_en(de),
        .width(width), .height(height), .shift_en(a_shift_en), .pad_sel(a_pad_sel),
        .res_code(a_res_code), .center_x(a_center_x), .center_y(a_center_y),
        .center_vld(a_center_vld), .win_valid(a_win_valid), .frame_start(a_frame_start),
        .frame_done(a_frame_done), .cfg_error(a_cfg_error)
`ifdef FAST_WIN_STATS_EN
        , .valid_cnt(a_valid_cnt), .valid_cnt_last(a_valid_cnt_last)
`endif
    );

    fast_window_ctrl #(.DIM_W(11), .BORDER(3), .ALLOW_ANY_RES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_H_SYNC(hs), .in_V_SYNC(vs), .in_data_en(de),
        .width(width), .height(height), .shift_en(b_shift_en), .pad_sel(b_pad_sel),
        .res_code(b_res_code), .center_x(b_center_x), .center_y(b_center_y),
        .center_vld(b_center_vld), .win_valid(b_win_valid), .frame_start(b_frame_start),
        .frame_done(b_frame_done), .cfg_error(b_cfg_error)
`ifdef FAST_WIN_STATS_EN
        , .valid_cnt(b_valid_cnt), .valid_cnt_last(b_valid_cnt_last)
`endif
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic vsync_rise(input int w, input int h);
        @(posedge clk); #1;
        width = 11'(w); height = 11'(h); vs = 1'b1; de = 1'b0;
        @(posedge clk); #1;
        vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        compared++;
        if ({a_shift_en, a_pad_sel, a_res_code, a_center_x, a_center_y, a_center_vld, a_win_valid,
             a_frame_start, a_frame_done, a_cfg_error} !== '0) begin
            mismatched++;
            $display("FAIL reset_a: outputs not zero, res_code=%b cfg_error=%b", a_res_code, a_cfg_error);
        end
        compared++;
        if ({b_shift_en, b_pad_sel, b_res_code, b_center_x, b_center_y, b_center_vld, b_win_valid,
             b_frame_start, b_frame_done, b_cfg_error} !== '0) begin
            mismatched++;
            $display("FAIL reset_b: outputs not zero, res_code=%b cfg_error=%b", b_res_code, b_cfg_error);
        end
    endtask

    task automatic test_illegal();
        vsync_rise(800, 600);
        compared++;
        if (a_cfg_error !== 1'b1 || a_res_code !== 2'b00 || a_frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_800x600: cfg_error=%b res=%b start=%b, want 1/00/0",
                     a_cfg_error, a_res_code, a_frame_start);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 de = 1'b1;
            @(negedge clk);
            compared++;
            if (a_shift_en !== 1'b0) begin
                mismatched++;
                $display("FAIL illegal_no_shift: shift_en=%b want 0", a_shift_en);
            end
        end
        de = 1'b0;
    endtask

    task automatic test_640();
        int starts;
        bit d;
        vsync_rise(640, 480);
        compared++;
        if (a_res_code !== 2'b01 || a_cfg_error !== 1'b0) begin
            mismatched++;
            $display("FAIL res_640: res=%b cfg_error=%b want 01/0", a_res_code, a_cfg_error);
        end
        starts = int'(a_frame_start);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            d = 1'($urandom_range(0, 1));
            de = d;
            @(negedge clk);
            starts += int'(a_frame_start);
            compared++;
            if (a_shift_en !== d || a_pad_sel !== 1'b0) begin
                mismatched++;
                $display("FAIL run_640_shift: shift_en=%b pad=%b want %b/0", a_shift_en, a_pad_sel, d);
            end
        end
        compared++;
        if (starts != 1) begin
            mismatched++;
            $display("FAIL frame_start_640: pulses=%0d want 1", starts);
        end
        do_reset();
    endtask

    task automatic test_1280_vsync_mid();
        vsync_rise(1280, 720);
        compared++;
        if (a_res_code !== 2'b10 || a_frame_start !== 1'b1) begin
            mismatched++;
            $display("FAIL res_1280: res=%b start=%b want 10/1", a_res_code, a_frame_start);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            de = 1'b1;
            vs = (i == 20);
        end
        @(negedge clk);
        compared++;
        if (a_cfg_error !== 1'b1 || a_shift_en !== 1'b1 || a_center_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL vsync_mid_1280: cfg_error=%b shift_en=%b cvld=%b want 1/1/0",
                     a_cfg_error, a_shift_en, a_center_vld);
        end
        do_reset();
    endtask

    task automatic run_frame(input int w, input int h, input bit toggle, input int vs_at, input string tag);
        int off, shifts, kidx, flush_left, since, centers, wins, dones, flushes, want_wins;
        bit de_v, in_run, exp_se, exp_ps, exp_cv, prev_cv, finished;
        center_t e;
        off = 3 * w + 3;
        want_wins = (w - 6) * (h - 6);
        exp_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                e.x = x; e.y = y;
                e.wv = (x >= 3 && x <= w - 4 && y >= 3 && y <= h - 4);
                exp_q.push_back(e);
            end
        vsync_rise(w, h);
        compared++;
        if (b_frame_start !== 1'b1 || b_res_code !== 2'b11 || b_cfg_error !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_start: start=%b res=%b cfg=%b want 1/11/0", tag, b_frame_start, b_res_code, b_cfg_error);
        end
        shifts = 0; kidx = 0; flush_left = off; since = -1;
        centers = 0; wins = 0; dones = 0; flushes = 0;
        prev_cv = 1'b0; finished = 1'b0;
        for (int it = 0; it < 2 * w * h + off + 20 && !finished; it++) begin
            @(posedge clk); #1;
            de_v = toggle ? (it % 2 == 0) : 1'b1;
            de = de_v;
            vs = (it == vs_at);
            in_run = shifts < w * h;
            exp_se = in_run ? de_v : (flush_left > 0);
            exp_ps = !in_run && flush_left > 0;
            exp_cv = exp_se && kidx >= off;
            @(negedge clk);
            compared++;
            if (b_shift_en !== exp_se || b_pad_sel !== exp_ps) begin
                mismatched++;
                $display("FAIL %s_shift it=%0d: shift_en=%b pad=%b want %b/%b", tag, it, b_shift_en, b_pad_sel, exp_se, exp_ps);
            end
            compared++;
            if (b_center_vld !== prev_cv || b_frame_done !== (since == 1)) begin
                mismatched++;
                $display("FAIL %s_timing it=%0d: cvld=%b done=%b want %b/%b", tag, it, b_center_vld, b_frame_done, prev_cv, since == 1);
            end
            if (b_center_vld === 1'b1) begin
                centers++;
                wins += int'(b_win_valid);
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL %s_center: unexpected center (%0d,%0d) want none", tag, b_center_x, b_center_y);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(b_center_x) != e.x || int'(b_center_y) != e.y || b_win_valid !== e.wv) begin
                        mismatched++;
                        $display("FAIL %s_center: got (%0d,%0d,wv=%b) want (%0d,%0d,wv=%b)",
                                 tag, b_center_x, b_center_y, b_win_valid, e.x, e.y, e.wv);
                    end
                end
            end
            dones += int'(b_frame_done);
            if (b_shift_en === 1'b1 && b_pad_sel === 1'b1) flushes++;
            prev_cv = exp_cv;
            if (exp_se) kidx++;
            if (in_run) begin
                if (de_v) shifts++;
            end else if (flush_left > 0) begin
                flush_left--;
                if (flush_left == 0) since = 0;
            end else begin
                since++;
                if (since >= 3) finished = 1'b1;
            end
        end
        de = 1'b0;
        vs = 1'b0;
        compared++;
        if (centers != w * h || wins != want_wins || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_totals: centers=%0d wins=%0d left=%0d want %0d/%0d/0",
                     tag, centers, wins, exp_q.size(), w * h, want_wins);
        end
        compared++;
        if (dones != 1 || flushes != off) begin
            mismatched++;
            $display("FAIL %s_flush: frame_done=%0d flush_cycles=%0d want 1/%0d", tag, dones, flushes, off);
        end
        compared++;
        if (b_cfg_error !== (vs_at >= 0)) begin
            mismatched++;
            $display("FAIL %s_cfg_error: got %b want %b", tag, b_cfg_error, vs_at >= 0);
        end
`ifdef FAST_WIN_STATS_EN
        compared++;
        if (int'(b_valid_cnt_last) != want_wins) begin
            mismatched++;
            $display("FAIL %s_valid_cnt_last: got %0d want %0d", tag, b_valid_cnt_last, want_wins);
        end
`endif
    endtask

    task automatic test_flush_reset();
        do_reset();
        vsync_rise(10, 10);
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1 de = 1'b1;
        end
        @(negedge clk);
        compared++;
        if (b_pad_sel !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_entry: pad_sel=%b want 1", b_pad_sel);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({b_shift_en, b_pad_sel, b_res_code, b_center_x, b_center_y, b_center_vld, b_win_valid,
             b_frame_start, b_frame_done, b_cfg_error} !== '0) begin
            mismatched++;
            $display("FAIL flush_reset: outputs not zero, shift=%b pad=%b cvld=%b", b_shift_en, b_pad_sel, b_center_vld);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            compared++;
            if (b_frame_done !== 1'b0 || b_shift_en !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_reset_idle: done=%b shift=%b want 0/0", b_frame_done, b_shift_en);
            end
        end
        de = 1'b0;
        run_frame(10, 10, 1'b0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_640();
        test_1280_vsync_mid();
        run_frame(10, 10, 1'b1, -1, "toggle_10x10");
        run_frame(16, 12, 1'b0, -1, "cont_16x12");
        run_frame(12, 9, 1'b0, 40, "vsync_mid_12x9");
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
